// File: rtl/any1_inst_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | any1_inst_align : ANY-1 instruction-align stage (fetch line -> 64-bit ir)  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+

package any1_pkg;
  localparam int AWID = 32;

  typedef struct packed {
    logic [5:0]      epoch;
    logic [5:0]      rid;
    logic [AWID-1:0] ip;
    logic [AWID-1:0] pip;
    logic            predict_taken;
    logic [511:0]    cacheline;
  } sInstAlignIn;

  typedef struct packed {
    logic [5:0]      epoch;
    logic [5:0]      rid;
    logic [AWID-1:0] ip;
    logic [AWID-1:0] pip;
    logic            predict_taken;
    logic [63:0]     ir;
  } sInstAlignOut;
endpackage

module any1_inst_align #(
  parameter int AWID       = any1_pkg::AWID,
  parameter int LINE_BYTES = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  any1_pkg::sInstAlignIn  in_i,
  input  logic                   flush_i,
  input  logic [5:0]             flush_epoch_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output any1_pkg::sInstAlignOut out_o,
  output logic [15:0]            drop_cnt_o
);
  import any1_pkg::*;

  localparam int c_OFF_W = $clog2(LINE_BYTES);
  localparam int c_LA_W  = AWID - c_OFF_W;
  localparam logic [c_OFF_W-1:0] c_LAST_NS_OFF = c_OFF_W'(LINE_BYTES - 8);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [5:0]    r_cur_epoch;
  // Held straddle entry; its ir field keeps the last 8 bytes of the first line.
  sInstAlignOut  r_held;
  sInstAlignOut  w_held_nxt;
  sInstAlignOut  r_out;
  sInstAlignOut  w_out_nxt;
  logic          r_out_valid;
  logic          w_load;
  logic [15:0]   r_drop_cnt;
  logic [15:0]   w_drop_nxt;
  logic [1:0]    w_drop_inc;
  logic [16:0]   w_drop_sum;
  logic          w_idle_path;

  logic               w_accept;
  logic               w_epoch_ok;
  logic               w_straddle;
  logic               w_line_match;
  logic [c_OFF_W-1:0] w_off;
  logic [c_OFF_W-1:0] w_held_sel;
  logic [c_LA_W-1:0]  w_next_line;
  logic [63:0]        w_ir_single;
  logic [127:0]       w_str_cat;
  logic [63:0]        w_ir_str;

  assign in_ready_o  = !flush_i && (!r_out_valid || out_ready_i);
  assign w_accept    = in_valid_i && in_ready_o;
  assign w_epoch_ok  = (in_i.epoch == r_cur_epoch);
  assign w_off       = in_i.ip[c_OFF_W-1:0];
  assign w_straddle  = (w_off > c_LAST_NS_OFF);

  assign w_next_line  = r_held.ip[AWID-1:c_OFF_W] + c_LA_W'(1);
  assign w_line_match = (in_i.ip[AWID-1:c_OFF_W] == w_next_line);

  assign w_ir_single = 64'(in_i.cacheline >> {w_off, 3'b000});

  // Tail bytes of the first line sit below the head bytes of the second.
  assign w_str_cat  = {in_i.cacheline[63:0], r_held.ir};
  assign w_held_sel = r_held.ip[c_OFF_W-1:0] - c_LAST_NS_OFF;
  assign w_ir_str   = 64'(w_str_cat >> {w_held_sel, 3'b000});

  always_comb begin
    w_state_nxt = r_state;
    w_held_nxt  = r_held;
    w_out_nxt   = r_out;
    w_load      = 1'b0;
    w_drop_inc  = 2'd0;
    w_idle_path = 1'b0;

    if (w_accept) begin
      w_idle_path = 1'b1;
      if (r_state == S_HOLD) begin
        w_state_nxt = S_IDLE;
        if (w_epoch_ok && w_line_match) begin
          w_idle_path  = 1'b0;
          w_load       = 1'b1;
          w_out_nxt    = r_held;
          w_out_nxt.ir = w_ir_str;
        end else begin
          w_drop_inc = 2'd1;
        end
      end

      if (w_idle_path) begin
        if (!w_epoch_ok) begin
          w_drop_inc = w_drop_inc + 2'd1;
        end else if (!w_straddle) begin
          w_load                  = 1'b1;
          w_out_nxt.epoch         = in_i.epoch;
          w_out_nxt.rid           = in_i.rid;
          w_out_nxt.ip            = in_i.ip;
          w_out_nxt.pip           = in_i.pip;
          w_out_nxt.predict_taken = in_i.predict_taken;
          w_out_nxt.ir            = w_ir_single;
        end else begin
          w_state_nxt              = S_HOLD;
          w_held_nxt.epoch         = in_i.epoch;
          w_held_nxt.rid           = in_i.rid;
          w_held_nxt.ip            = in_i.ip;
          w_held_nxt.pip           = in_i.pip;
          w_held_nxt.predict_taken = in_i.predict_taken;
          w_held_nxt.ir            = in_i.cacheline[8*LINE_BYTES-1 -: 64];
        end
      end
    end
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop_inc);
  assign w_drop_nxt = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_cur_epoch <= 6'd0;
      r_held      <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_drop_cnt  <= 16'd0;
    end else if (flush_i) begin
      r_state     <= S_IDLE;
      r_cur_epoch <= flush_epoch_i;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_held      <= w_held_nxt;
      r_out       <= w_out_nxt;
      r_out_valid <= w_load || (r_out_valid && !out_ready_i);
      r_drop_cnt  <= w_drop_nxt;
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_o       = r_out;
  assign drop_cnt_o  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_any1_inst_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_any1_inst_align : directed vectors, random traffic vs reference model   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_any1_inst_align;
  import any1_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         in_valid_i;
  logic         in_ready_o;
  sInstAlignIn  in_i;
  logic         flush_i;
  logic [5:0]   flush_epoch_i;
  logic         out_valid_o;
  logic         out_ready_i;
  sInstAlignOut out_o;
  logic [15:0]  drop_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  any1_inst_align #(.AWID(32), .LINE_BYTES(64)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_i         (in_i),
    .flush_i      (flush_i),
    .flush_epoch_i(flush_epoch_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_o        (out_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  typedef struct {
    logic        v;
    logic [31:0] ip;
    logic [5:0]  ep;
    logic [7:0]  base;
    logic        ordy;
    logic        fl;
    logic [5:0]  fe;
    logic        e_rdy;
    logic        e_ov;
    logic [63:0] e_ir;
    logic [31:0] e_ip;
    logic [15:0] e_drop;
  } vec_t;

  vec_t tbl[21];

  // Reference model state
  logic         m_ov;
  sInstAlignOut m_out;
  logic [5:0]   m_epoch;
  logic         m_hold;
  sInstAlignIn  m_held;
  int           m_drop;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mkline(input logic [7:0] base);
    logic [511:0] l;
    for (int k = 0; k < 64; k++) l[8*k +: 8] = base + 8'(k);
    return l;
  endfunction

  function automatic logic [511:0] rndline();
    logic [511:0] l;
    for (int w = 0; w < 16; w++) l[32*w +: 32] = $urandom;
    return l;
  endfunction

  // Byte k of the instruction is byte off+k of the concatenated line stream.
  function automatic logic [63:0] pick(input logic [511:0] a, input logic [511:0] b, input int off);
    logic [63:0] r;
    int idx;
    for (int j = 0; j < 8; j++) begin
      idx = off + j;
      if (idx < 64) r[8*j +: 8] = a[8*idx +: 8];
      else          r[8*j +: 8] = b[8*(idx-64) +: 8];
    end
    return r;
  endfunction

  function automatic sInstAlignOut mkout(input sInstAlignIn e, input logic [63:0] ir);
    sInstAlignOut o;
    o.epoch = e.epoch; o.rid = e.rid; o.ip = e.ip; o.pip = e.pip;
    o.predict_taken = e.predict_taken; o.ir = ir;
    return o;
  endfunction

  task automatic drive(input logic v, input logic [31:0] ip, input logic [5:0] ep,
                       input logic [511:0] line, input logic ordy, input logic fl,
                       input logic [5:0] fe);
    in_valid_i = v;
    in_i.epoch = ep;
    in_i.rid = ip[7:2];
    in_i.ip = ip;
    in_i.pip = ip ^ 32'h1000;
    in_i.predict_taken = ip[2];
    in_i.cacheline = line;
    out_ready_i = ordy;
    flush_i = fl;
    flush_epoch_i = fe;
  endtask

  task automatic model_reset();
    m_ov = 1'b0; m_out = '0; m_epoch = 6'd0; m_hold = 1'b0; m_held = '0; m_drop = 0;
  endtask

  task automatic model_step(input logic rdy);
    logic acc;
    logic proc;
    logic load;
    acc = in_valid_i && rdy;
    load = 1'b0;
    if (flush_i) begin
      m_epoch = flush_epoch_i; m_hold = 1'b0; m_ov = 1'b0;
      return;
    end
    if (acc) begin
      proc = 1'b1;
      if (m_hold) begin
        if (in_i.epoch == m_epoch && in_i.ip[31:6] == m_held.ip[31:6] + 26'd1) begin
          m_out = mkout(m_held, pick(m_held.cacheline, in_i.cacheline, int'(m_held.ip[5:0])));
          load = 1'b1; proc = 1'b0;
        end else begin
          m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
        end
        m_hold = 1'b0;
      end
      if (proc) begin
        if (in_i.epoch != m_epoch) m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
        else if (in_i.ip[5:0] <= 6'd56) begin
          m_out = mkout(in_i, pick(in_i.cacheline, '0, int'(in_i.ip[5:0])));
          load = 1'b1;
        end else begin
          m_hold = 1'b1; m_held = in_i;
        end
      end
    end
    if (load) m_ov = 1'b1;
    else if (out_ready_i) m_ov = 1'b0;
  endtask

  initial begin
    logic       e_rdy;
    logic [25:0] la;
    logic [5:0]  off;
    logic [5:0]  ep;

    tbl[0]  = '{1'b0, 32'h0,        6'd0, 8'h00, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 64'h0,                 32'h0,        16'd0};
    tbl[1]  = '{1'b1, 32'hFFFD0008, 6'd0, 8'h00, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 64'h0,                 32'h0,        16'd0};
    tbl[2]  = '{1'b1, 32'h0000003C, 6'd0, 8'h00, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1, 64'h0F0E0D0C0B0A0908, 32'hFFFD0008, 16'd0};
    tbl[3]  = '{1'b1, 32'h00000040, 6'd0, 8'h80, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 64'h0,                 32'h0,        16'd0};
    tbl[4]  = '{1'b0, 32'h0,        6'd0, 8'h00, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1, 64'h838281803F3E3D3C, 32'h0000003C, 16'd0};
    tbl[5]  = '{1'b1, 32'h0000007C, 6'd0, 8'h00, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 64'h0,                 32'h0,        16'd0};
    tbl[6]  = '{1'b1, 32'h00000200, 6'd0, 8'h40, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 64'h0,                 32'h0,        16'd0};
    tbl[7]  = '{1'b1, 32'h00000010, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 64'h4746454443424140, 32'h00000200, 16'd1};
    tbl[8]  = '{1'b1, 32'h00000010, 6'd0, 8'h00, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 64'h4746454443424140, 32'h00000200, 16'd1};
    tbl[9]  = '{1'b1, 32'h00000010, 6'd0, 8'h00, 1'b0, 1'b1, 6'd5, 1'b0, 1'b1, 64'h4746454443424140, 32'h00000200, 16'd1};
    tbl[10] = '{1'b1, 32'h00000010, 6'd4, 8'h00, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 64'h0,                 32'h0,        16'd1};
    tbl[11] = '{1'b1, 32'h0000007C, 6'd5, 8'h00, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 64'h0,                 32'h0,        16'd2};
    tbl[12] = '{1'b1, 32'h00000080, 6'd5, 8'h80, 1'b1, 1'b1, 6'd6, 1'b0, 1'b0, 64'h0,                 32'h0,        16'd2};
    tbl[13] = '{1'b1, 32'h00000080, 6'd6, 8'h80, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 64'h0,                 32'h0,        16'd2};
    tbl[14] = '{1'b1, 32'h00000008, 6'd6, 8'h00, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1, 64'h8786858483828180, 32'h00000080, 16'd2};
    tbl[15] = '{1'b1, 32'h00000010, 6'd6, 8'h00, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1, 64'h0F0E0D0C0B0A0908, 32'h00000008, 16'd2};
    tbl[16] = '{1'b0, 32'h0,        6'd6, 8'h00, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1, 64'h1716151413121110, 32'h00000010, 16'd2};
    tbl[17] = '{1'b1, 32'hFFFFFFFC, 6'd6, 8'h10, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 64'h0,                 32'h0,        16'd2};
    tbl[18] = '{1'b1, 32'h00000000, 6'd6, 8'h90, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 64'h0,                 32'h0,        16'd2};
    tbl[19] = '{1'b0, 32'h0,        6'd6, 8'h00, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1, 64'h939291904F4E4D4C, 32'hFFFFFFFC, 16'd2};
    tbl[20] = '{1'b0, 32'h0,        6'd6, 8'h00, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 64'h0,                 32'h0,        16'd2};

    rst_ni = 1'b0;
    drive(1'b0, 32'h0, 6'd0, '0, 1'b1, 1'b0, 6'd0);
    repeat (2) @(negedge clk_i);
    #1;
    chk("reset_ov", out_valid_o, 1'b0);
    chk("reset_out", out_o, '0);
    chk("reset_drop", drop_cnt_o, 16'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Directed vectors: expected values are those seen before the edge of that row.
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].v, tbl[i].ip, tbl[i].ep, mkline(tbl[i].base), tbl[i].ordy, tbl[i].fl, tbl[i].fe);
      #1;
      chk($sformatf("vec%0d_rdy", i), in_ready_o, tbl[i].e_rdy);
      chk($sformatf("vec%0d_ov", i), out_valid_o, tbl[i].e_ov);
      chk($sformatf("vec%0d_drop", i), drop_cnt_o, tbl[i].e_drop);
      if (tbl[i].e_ov) begin
        chk($sformatf("vec%0d_ir", i), out_o.ir, tbl[i].e_ir);
        chk($sformatf("vec%0d_ip", i), out_o.ip, tbl[i].e_ip);
        chk($sformatf("vec%0d_rid", i), out_o.rid, tbl[i].e_ip[7:2]);
        chk($sformatf("vec%0d_pip", i), out_o.pip, tbl[i].e_ip ^ 32'h1000);
      end
      @(negedge clk_i);
    end

    // Asynchronous reset while a straddle is held, then an entry that would
    // complete that straddle must be taken as a fresh aligned entry.
    drive(1'b1, 32'h0000003C, 6'd6, mkline(8'h00), 1'b1, 1'b0, 6'd0);
    @(negedge clk_i);
    drive(1'b0, 32'h0, 6'd0, '0, 1'b1, 1'b0, 6'd0);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_ov", out_valid_o, 1'b0);
    chk("arst_drop", drop_cnt_o, 16'd0);
    chk("arst_out", out_o, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(1'b1, 32'h00000040, 6'd0, mkline(8'h00), 1'b1, 1'b0, 6'd0);
    @(negedge clk_i);
    drive(1'b0, 32'h0, 6'd0, '0, 1'b1, 1'b0, 6'd0);
    #1;
    chk("arst_after_ov", out_valid_o, 1'b1);
    chk("arst_after_ir", out_o.ir, 64'h0706050403020100);
    chk("arst_after_ip", out_o.ip, 32'h00000040);
    chk("arst_after_drop", drop_cnt_o, 16'd0);

    // Randomized traffic against the reference model
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    rst_ni = 1'b1;
    model_reset();
    @(negedge clk_i);
    for (int c = 0; c < 2000; c++) begin
      if (m_hold && $urandom_range(0, 3) != 0) la = m_held.ip[31:6] + 26'd1;
      else la = 26'($urandom);
      off = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(57, 63)) : 6'($urandom_range(0, 63));
      ep = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 3)) : m_epoch;
      drive($urandom_range(0, 3) != 0, {la, off}, ep, rndline(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, 6'($urandom_range(0, 3)));
      in_i.rid = 6'($urandom);
      in_i.pip = $urandom;
      in_i.predict_taken = 1'($urandom);
      #1;
      e_rdy = !flush_i && (!m_ov || out_ready_i);
      chk("rnd_rdy", in_ready_o, e_rdy);
      chk("rnd_ov", out_valid_o, m_ov);
      chk("rnd_drop", drop_cnt_o, 16'(m_drop));
      if (m_ov) chk("rnd_out", out_o, m_out);
      @(posedge clk_i);
      model_step(e_rdy);
      @(negedge clk_i);
    end

    // Counter saturation: a steady stream of stale-epoch entries
    drive(1'b1, 32'h00000008, m_epoch ^ 6'h1, mkline(8'h00), 1'b1, 1'b0, 6'd0);
    repeat (65540) @(negedge clk_i);
    #1;
    chk("drop_saturate", drop_cnt_o, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
